// File: rtl/sar_adc8.sv
// sar_adc8: successive-approximation ADC behavioural model.
// Holds Vin/Vref after a configurable acquisition window, then resolves one
// bit per clock, MSB first, by comparing the held input against a DAC-style
// trial level Vref_h*trial/(2^N_BITS-1). All outputs are registered.
module sar_adc8 #(
  parameter int N_BITS     = 8,
  parameter int ACQ_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  real               Vin,
  input  real               Vref,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] dout,
  output logic              ovr
);

  localparam int  IW         = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam real FULL_SCALE = real'((1 << N_BITS) - 1);
  localparam logic [N_BITS-1:0] LSB_ONE = {{(N_BITS-1){1'b0}}, 1'b1};
  localparam logic [N_BITS-1:0] MSB_ONE = {1'b1, {(N_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT,
    ST_DONE
  } state_t;

  state_t            state_reg;
  logic [7:0]        acq_cnt_reg;
  logic [N_BITS-1:0] trial_reg;
  logic [IW-1:0]     bit_idx_reg;
  real               vin_h_reg;
  real               vref_h_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [N_BITS-1:0] dout_reg;
  logic              ovr_reg;

  logic [N_BITS-1:0] bit_mask;
  logic              keep_bit;
  logic [N_BITS-1:0] resolved;

  // Trial comparison for the bit currently under test; resolved is the trial
  // word with that bit either kept or cleared.
  always_comb begin
    bit_mask = LSB_ONE << bit_idx_reg;
    keep_bit = (vin_h_reg >= (vref_h_reg * real'(trial_reg) / FULL_SCALE));
    resolved = keep_bit ? trial_reg : (trial_reg & ~bit_mask);
  end

  // Conversion FSM with registered outputs; reset discards any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      acq_cnt_reg <= 8'd0;
      trial_reg   <= '0;
      bit_idx_reg <= '0;
      vin_h_reg   <= 0.0;
      vref_h_reg  <= 0.0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      dout_reg    <= '0;
      ovr_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg   <= ST_SAMPLE;
            acq_cnt_reg <= 8'd0;
            busy_reg    <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          acq_cnt_reg <= acq_cnt_reg + 8'd1;
          if (acq_cnt_reg == 8'(ACQ_CYCLES - 1)) begin
            // Inputs are frozen here; later changes cannot disturb the result.
            vin_h_reg   <= Vin;
            vref_h_reg  <= Vref;
            trial_reg   <= MSB_ONE;
            bit_idx_reg <= IW'(N_BITS - 1);
            state_reg   <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (bit_idx_reg != '0) begin
            trial_reg   <= resolved | (bit_mask >> 1);
            bit_idx_reg <= bit_idx_reg - IW'(1);
          end else begin
            trial_reg <= resolved;
            dout_reg  <= resolved;
            ovr_reg   <= (vin_h_reg > vref_h_reg);
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here; it must be seen in IDLE.
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign dout = dout_reg;
  assign ovr  = ovr_reg;

endmodule

// File: tb/tb_sar_adc8.sv
// tb_sar_adc8: directed, table-driven checks of sar_adc8 with default
// parameters, plus hand-written sequences for hold, reset and streaming.
module tb_sar_adc8;

  logic       clk;
  logic       rst_n;
  logic       start;
  real        vin_s;
  real        vref_s;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic       ovr;

  int compared;
  int mismatched;

  sar_adc8 #(.N_BITS(8), .ACQ_CYCLES(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Vin   (vin_s),
    .Vref  (vref_s),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .ovr   (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int         vin_mv;
    int         vref_mv;
    logic [7:0] exp_code;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string name);
    check({name, " busy"}, int'(busy), 0);
    check({name, " done"}, int'(done), 0);
    check({name, " dout"}, int'(dout), 0);
    check({name, " ovr"},  int'(ovr),  0);
  endtask

  // One-cycle start pulse; reports done latency (edges after the start edge),
  // busy cycle count, number of done pulses and the captured result.
  task automatic run_conv(input real vin, input real vref,
                          output int lat, output int busy_cnt, output int done_cnt,
                          output int code, output int o);
    int k;
    vin_s = vin; vref_s = vref;
    lat = -1; busy_cnt = 0; done_cnt = 0; code = -1; o = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (k < 40) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin lat = k; code = int'(dout); o = int'(ovr); end
      end
      if (!busy && k > 0) break;
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int lat, bc, dc, code, o, dcount, cyc, j, last_cyc, prev_code, expc;
    real cur_vin;
    compared = 0; mismatched = 0;
    rst_n = 1'b0; start = 1'b0; vin_s = 0.0; vref_s = 1.0;

    vecs[0] = '{300,  1000, 8'd76,  1'b0};
    vecs[1] = '{0,    1000, 8'd0,   1'b0};
    vecs[2] = '{500,  1000, 8'd127, 1'b0};
    vecs[3] = '{1000, 1000, 8'd255, 1'b0};
    vecs[4] = '{1300, 1000, 8'd255, 1'b1};
    vecs[5] = '{-200, 1000, 8'd0,   1'b0};
    vecs[6] = '{2500, 3300, 8'd193, 1'b0};
    vecs[7] = '{750,  1000, 8'd191, 1'b0};

    // Reset held three cycles, then 20 idle cycles with start low.
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle_zero("idle");
    end

    // Table of single conversions.
    for (int i = 0; i < 8; i++) begin
      run_conv(real'(vecs[i].vin_mv) / 1000.0, real'(vecs[i].vref_mv) / 1000.0,
               lat, bc, dc, code, o);
      $display("vec %0d: vin=%0dmV vref=%0dmV -> dout=%0d ovr=%0d lat=%0d busy=%0d",
               i, vecs[i].vin_mv, vecs[i].vref_mv, code, o, lat, bc);
      check("vec dout", code, int'(vecs[i].exp_code));
      check("vec ovr", o, int'(vecs[i].exp_ovr));
      check("vec latency", lat, 9);
      check("vec busy cycles", bc, 10);
      check("vec done pulses", dc, 1);
    end

    // Hold: Vin moves during CONVERT; start pulses while busy and in DONE.
    vref_s = 2.0; vin_s = 1.0; dcount = 0; code = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      if (k == 1) begin vin_s = 0.0; start = 1'b1; end
      if (k == 2) start = 1'b0;
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
      if (done) begin
        dcount++;
        code = int'(dout);
        start = 1'b1;
      end
      if (k == 10) start = 1'b0;
    end
    $display("hold: dout=%0d done pulses=%0d", code, dcount);
    check("hold dout", code, 127);
    check("hold done pulses", dcount, 1);
    check("hold busy after", int'(busy), 0);

    // Leave dout/ovr nonzero, then reset during the 4th CONVERT cycle.
    run_conv(1.3, 1.0, lat, bc, dc, code, o);
    check("pre-reset dout", code, 255);
    vin_s = 0.3; vref_s = 1.0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("mid-conv reset: busy=%0d done=%0d dout=%0d ovr=%0d", busy, done, dout, ovr);
    check_idle_zero("async reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("post-reset done pulses", dcount, 0);
    check_idle_zero("post-reset idle");
    run_conv(0.3, 1.0, lat, bc, dc, code, o);
    $display("after reset: dout=%0d lat=%0d", code, lat);
    check("after reset dout", code, 76);
    check("after reset latency", lat, 9);

    // Streaming sweep with start held high.
    vref_s = 1.0; cur_vin = 0.5 / 255.0; vin_s = cur_vin;
    cyc = 0; j = 0; last_cyc = 0; prev_code = 0;
    @(negedge clk); start = 1'b1;
    while (j < 11 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        expc = int'($floor(cur_vin * 255.0 / vref_s));
        if (expc < 0) expc = 0;
        if (expc > 255) expc = 255;
        $display("sweep %0d: cycle=%0d dout=%0d expected=%0d", j, cyc, dout, expc);
        check("sweep dout", int'(dout), expc);
        if (j > 0) begin
          check("sweep period", cyc - last_cyc, 11);
          check("sweep monotonic", int'(int'(dout) >= prev_code), 1);
        end
        prev_code = int'(dout);
        last_cyc = cyc;
        j++;
        cur_vin = (25.0 * real'(j) + 0.5) / 255.0;
        vin_s = cur_vin;
      end
    end
    start = 1'b0;
    check("sweep conversions", j, 11);
    repeat (15) @(negedge clk);
    check("sweep drained busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
